// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: PC/IF-ID/ID-EXE advance, hold and flush control for a 5-stage MIPS pipeline,
// with multi-cycle EXE wait state, watchdog, and stall/flush performance counters.
module pipeline_hazard_controller #(
  parameter int LONG_OP_MAX_CYCLES = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt_reg,
  input  logic             ex_long_start,
  input  logic             ex_long_done,
  input  logic             mem_branch_taken,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             long_abort,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
  localparam int WD_W = $clog2(LONG_OP_MAX_CYCLES + 1);
  typedef enum logic {RUN = 1'b0, LONG_WAIT = 1'b1} state_t;
  state_t state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic load_use, long_stall, wd_expire;
  assign load_use = id_ex_mem_read && id_ex_rt_reg != 5'd0 &&
                    (id_ex_rt_reg == id_rs || (id_uses_rt && id_ex_rt_reg == id_rt));
  // Start and done together is a single-cycle op, so it never stalls.
  assign long_stall = !ex_long_done && (state_q == LONG_WAIT || ex_long_start);
  assign wd_expire = state_q == LONG_WAIT && !ex_long_done && wd_q == WD_W'(LONG_OP_MAX_CYCLES - 1);
  assign timeout_err = timeout_q && !rst;
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    if (mem_branch_taken) begin
      state_d = RUN;
      wd_d    = '0;
    end else if (state_q == RUN) begin
      state_d = ex_long_start && !ex_long_done ? LONG_WAIT : RUN;
      wd_d    = '0;
    end else if (ex_long_done) begin
      state_d = RUN;
    end else if (wd_expire) begin
      state_d   = RUN;
      wd_d      = '0;
      timeout_d = 1'b1;
    end else begin
      wd_d = wd_q + 1'b1;
    end
    stall_d = stall_q + CNT_W'(!pc_write);
    flush_d = flush_q + CNT_W'(pc_sel != 2'd0);
  end
  always_comb begin
    pc_write      = 1'b1;
    pc_sel        = 2'd0;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    long_abort    = 1'b0;
    if (rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      long_abort    = 1'b1;
    end else if (mem_branch_taken) begin
      pc_sel        = 2'd1;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      long_abort    = state_q == LONG_WAIT;
    end else if (long_stall) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_bubble = 1'b1;
      long_abort    = wd_expire;
    end else if (state_q == RUN && load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (state_q == RUN && id_jump) begin
      pc_sel      = 2'd2;
      if_id_flush = 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed checks of stalls, flushes, long ops, watchdog and reset.
module tb_pipeline_hazard_controller;
  localparam int CNT_W = 16;
  localparam logic [8:0] O_DEF = 9'b1_00_1_0_1_0_0_0;
  localparam logic [8:0] O_RST = 9'b0_00_0_1_0_1_1_1;
  localparam logic [8:0] O_BR  = 9'b1_01_1_1_1_1_1_0;
  localparam logic [8:0] O_BRA = 9'b1_01_1_1_1_1_1_1;
  localparam logic [8:0] O_LNG = 9'b0_00_0_0_0_0_1_0;
  localparam logic [8:0] O_TO  = 9'b0_00_0_0_0_0_1_1;
  localparam logic [8:0] O_LU  = 9'b0_00_0_0_1_1_0_0;
  localparam logic [8:0] O_JMP = 9'b1_10_1_1_1_0_0_0;
  logic clk = 1'b0, rst;
  logic [4:0] id_rs, id_rt, id_ex_rt_reg;
  logic id_uses_rt, id_jump, id_ex_mem_read, ex_long_start, ex_long_done, mem_branch_taken;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble, long_abort, timeout_err;
  logic [1:0] pc_sel;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic [8:0] outs;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign outs = {pc_write, pc_sel, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble, long_abort};
  pipeline_hazard_controller #(.LONG_OP_MAX_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt_reg(id_ex_rt_reg), .ex_long_start(ex_long_start),
    .ex_long_done(ex_long_done), .mem_branch_taken(mem_branch_taken), .pc_write(pc_write), .pc_sel(pc_sel),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble),
    .ex_mem_bubble(ex_mem_bubble), .long_abort(long_abort), .timeout_err(timeout_err),
    .stall_cycles(stall_cycles), .flush_events(flush_events));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1; id_rs = '0; id_rt = '0; id_ex_rt_reg = '0; id_uses_rt = 1'b0; id_jump = 1'b0;
    id_ex_mem_read = 1'b0; ex_long_start = 1'b0; ex_long_done = 1'b0; mem_branch_taken = 1'b0;
    cyc();
    chk("rst_outs", 32'(outs), 32'(O_RST));
    chk("rst_timeout", 32'(timeout_err), 0);
    chk("rst_stall", 32'(stall_cycles), 0);
    chk("rst_flush", 32'(flush_events), 0);
    rst = 1'b0; #1;
    chk("idle_outs", 32'(outs), 32'(O_DEF));
    cyc();
    chk("idle_stall", 32'(stall_cycles), 0);
    id_ex_mem_read = 1'b1; id_ex_rt_reg = 5'd8; id_rs = 5'd8; #1;
    chk("lu_rs_outs", 32'(outs), 32'(O_LU));
    cyc();
    chk("lu_stall1", 32'(stall_cycles), 1);
    id_ex_mem_read = 1'b0; #1;
    chk("lu_after", 32'(outs), 32'(O_DEF));
    cyc();
    chk("lu_stall_once", 32'(stall_cycles), 1);
    id_ex_mem_read = 1'b1; id_ex_rt_reg = 5'd0; id_rs = 5'd0; #1;
    chk("lu_r0", 32'(outs), 32'(O_DEF));
    id_ex_rt_reg = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0; #1;
    chk("lu_rt_unused", 32'(outs), 32'(O_DEF));
    id_uses_rt = 1'b1; #1;
    chk("lu_rt_used", 32'(outs), 32'(O_LU));
    id_ex_mem_read = 1'b0; id_uses_rt = 1'b0; #1;
    cyc();
    chk("lu_stall_hold", 32'(stall_cycles), 1);
    mem_branch_taken = 1'b1; #1;
    chk("br_outs", 32'(outs), 32'(O_BR));
    cyc();
    mem_branch_taken = 1'b0;
    chk("br_flush", 32'(flush_events), 1);
    chk("br_stall", 32'(stall_cycles), 1);
    id_jump = 1'b1; id_ex_mem_read = 1'b1; id_ex_rt_reg = 5'd8; id_rs = 5'd8; #1;
    chk("jlu_stall", 32'(outs), 32'(O_LU));
    cyc();
    chk("jlu_stallcnt", 32'(stall_cycles), 2);
    chk("jlu_flush_deferred", 32'(flush_events), 1);
    id_ex_mem_read = 1'b0; #1;
    chk("jmp_outs", 32'(outs), 32'(O_JMP));
    cyc();
    id_jump = 1'b0;
    chk("jmp_flush", 32'(flush_events), 2);
    ex_long_start = 1'b1; #1;
    chk("long_start", 32'(outs), 32'(O_LNG));
    cyc();
    ex_long_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("long_wait", 32'(outs), 32'(O_LNG));
      cyc();
    end
    ex_long_done = 1'b1; #1;
    chk("long_done", 32'(outs), 32'(O_DEF));
    cyc();
    ex_long_done = 1'b0; #1;
    chk("long_stall", 32'(stall_cycles), 6);
    chk("long_back_run", 32'(outs), 32'(O_DEF));
    ex_long_start = 1'b1; ex_long_done = 1'b1; #1;
    chk("long_single", 32'(outs), 32'(O_DEF));
    cyc();
    ex_long_done = 1'b0; #1;
    chk("long_single_run", 32'(outs), 32'(O_LNG));
    cyc();
    ex_long_start = 1'b0; #1;
    chk("lw_br_wait1", 32'(outs), 32'(O_LNG));
    cyc();
    mem_branch_taken = 1'b1; #1;
    chk("lw_br_abort", 32'(outs), 32'(O_BRA));
    cyc();
    mem_branch_taken = 1'b0; #1;
    chk("lw_br_run", 32'(outs), 32'(O_DEF));
    chk("lw_br_flush", 32'(flush_events), 3);
    chk("lw_br_stall", 32'(stall_cycles), 8);
    ex_long_start = 1'b1; #1;
    cyc();
    ex_long_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wd_wait", 32'(outs), 32'(O_LNG));
      cyc();
    end
    #1;
    chk("wd_expire", 32'(outs), 32'(O_TO));
    chk("wd_not_yet", 32'(timeout_err), 0);
    cyc();
    chk("wd_timeout", 32'(timeout_err), 1);
    chk("wd_run", 32'(outs), 32'(O_DEF));
    chk("wd_stall", 32'(stall_cycles), 13);
    mem_branch_taken = 1'b1;
    cyc();
    mem_branch_taken = 1'b0;
    cyc();
    chk("wd_sticky", 32'(timeout_err), 1);
    ex_long_start = 1'b1; #1;
    cyc();
    ex_long_start = 1'b0; #1;
    chk("rstlw_wait", 32'(outs), 32'(O_LNG));
    rst = 1'b1; #1;
    chk("rstlw_outs", 32'(outs), 32'(O_RST));
    chk("rstlw_timeout", 32'(timeout_err), 0);
    cyc();
    chk("rstlw_stall", 32'(stall_cycles), 0);
    chk("rstlw_flush", 32'(flush_events), 0);
    rst = 1'b0; #1;
    chk("rstlw_run", 32'(outs), 32'(O_DEF));
    cyc();
    chk("rstlw_timeout_clr", 32'(timeout_err), 0);
    chk("rstlw_stall_after", 32'(stall_cycles), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
